nes_mem_arbiter: RTL and testbench
==================================

// Module: nes_mem_arbiter
// PURPOSE
//  Arbitrates the single SDRAM controller port between the ROM loader write stream and the NES
//  CPU/PPU memory bus, and generates the 4-phase NES clock-enable and SDRAM clkref.
//  Sits between GameLoader/data_io, the NES core and the sdram block.
//  Replaces the ad-hoc loader write retiming and the nes_ce counter at top level.
// PARAMETERS
//  ADDR_W      22  NES/loader byte address width
//  SD_ADDR_W   25  SDRAM controller address width; NES address zero-extended into it
//  FIFO_DEPTH  4   loader write buffer entries; power of two, >=2
// PORTS
//  clk          in   1          NES system clock; single clock domain
//  reset_n      in   1          synchronous reset, active-low
//  downloading  in   1          data_io download in progress
//  ld_wr        in   1          loader write pulse; one clk wide
//  ld_addr      in   ADDR_W     loader address, valid with ld_wr
//  ld_data      in   8          loader data, valid with ld_wr
//  nes_addr     in   ADDR_W     NES memory address
//  nes_we       in   1          NES write request
//  nes_din      in   8          NES write data
//  nes_oe_cpu   in   1          CPU read request
//  nes_oe_ppu   in   1          PPU read request
//  nes_ce       out  1          NES clock enable; high when phase==3
//  sd_clkref    out  1          phase[1], feeds sdram clkref
//  nes_hold     out  1          high in LOAD/DRAIN; top level ORs it into the NES reset
//  sd_addr      out  SD_ADDR_W  SDRAM address
//  sd_we        out  1          SDRAM write
//  sd_din       out  8          SDRAM write data
//  sd_oe_a      out  1          SDRAM read, port A (CPU)
//  sd_oe_b      out  1          SDRAM read, port B (PPU)
//  ld_overflow  out  1          sticky: a loader write was dropped; cleared by reset only
// BEHAVIOUR
//  - Reset (reset_n==0 at a clk edge): phase=0, state=NES, FIFO empty, ld_overflow=0.
//    Every output is 0 except sd_clkref, which tracks phase[1]. Reset mid-load discards the FIFO.
//  - phase[1:0] increments every clk and wraps 3->0. nes_ce=(phase==3); sd_clkref=phase[1].
//  - FIFO push: ld_wr pushes {ld_addr,ld_data}. A push while full drops the entry and sets ld_overflow.
//    A push and a pop in the same cycle are both taken, even when full.
//  - FSM states: NES, LOAD, DRAIN. Transitions are evaluated only when phase==3:
//    NES->LOAD if downloading; LOAD->DRAIN if !downloading && FIFO not empty;
//    LOAD->NES if !downloading && FIFO empty; DRAIN->NES when FIFO empty after the pop.
//  - Write-slot register wr_act/wr_addr/wr_data, updated at phase==3 only:
//    in LOAD/DRAIN, pop one FIFO entry into it (wr_act=1), or set wr_act=0 if the FIFO is empty.
//    Each write is therefore held for exactly 4 clk (one NES cycle). Throughput: 1 entry per NES cycle.
//  - Output mux (registered, valid 1 clk after the state/slot update):
//    NES:        sd_addr={0,nes_addr}, sd_we=nes_we, sd_din=nes_din, sd_oe_a=nes_oe_cpu, sd_oe_b=nes_oe_ppu.
//    LOAD/DRAIN: sd_addr={0,wr_addr}, sd_we=wr_act, sd_din=wr_data, sd_oe_a=sd_oe_b=0; NES requests ignored.
//  - nes_hold=1 in LOAD and DRAIN; it deasserts on the same edge the state returns to NES.
//  - Phase changes never truncate a write window: all switches happen only at phase==3.
// CONFIGURATION
//  ARB_PERF_EN defined: adds outputs perf_ld_writes[23:0] (count of committed loader writes)
//    and perf_max_fill[$clog2(FIFO_DEPTH):0] (FIFO high-water mark). Both clear on reset and saturate.
//  ARB_PERF_EN undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package nes_mem_pkg: ARB_NES/ARB_LOAD/ARB_DRAIN state encodings, PH_CE=2'd3, default widths,
//    and the loader-entry struct {addr, data}.
//  Sub-module nes_arb_fifo: synchronous FIFO with push, pop, full, empty and count outputs.
//  The FSM, phase counter and output mux are implemented in this module.
// TESTING
//  1 Reset release, no activity: nes_ce pulses every 4th clk; sd_clkref=0,0,1,1; state=NES.
//  2 NES pass-through: nes_addr=22'h1234, nes_oe_cpu=1 -> sd_addr=25'h0001234, sd_oe_a=1 one clk later.
//  3 downloading=1 with 3 writes (0x000000/AA, 0x000001/BB, 0x200000/CC), each 8 clk apart
//    -> each sd_we window is 4 clk, addresses and data in order, sd_oe_a/b=0, nes_hold=1.
//  4 Burst of 6 ld_wr on consecutive clk, FIFO_DEPTH=4 -> ld_overflow=1; exactly the first entries
//    accepted by the FIFO are written, in order; the dropped ones never appear on sd_we.
//  5 downloading drops while 2 entries are queued -> DRAIN, 2 further write windows, then NES
//    at phase==3; nes_hold falls on that edge.
//  6 reset_n=0 mid-LOAD with 3 entries queued -> next clk: all outputs 0, FIFO empty, no further writes.

Source files
------------

// File: rtl/nes_mem_pkg.sv
// nes_mem_pkg: shared types and defaults for the NES SDRAM arbiter.
// States, clock-enable phase, default widths and the loader FIFO entry.
package nes_mem_pkg;

  localparam int ADDR_W_DEF     = 22;
  localparam int SD_ADDR_W_DEF  = 25;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic [1:0] PH_CE = 2'd3;

  typedef enum logic [1:0] {
    ARB_NES   = 2'd0,
    ARB_LOAD  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [7:0]            data;
  } ld_entry_t;

endpackage

// File: rtl/nes_mem_arbiter_if.sv
// nes_mem_arbiter_if: NES memory bus in, SDRAM controller port out.
// master = arbiter (reads nes_*, drives sd_*); slave = NES core + sdram side.
interface nes_mem_arbiter_if
  import nes_mem_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int SD_ADDR_W = SD_ADDR_W_DEF
);

  logic [ADDR_W-1:0]    nes_addr;
  logic                 nes_we;
  logic [7:0]           nes_din;
  logic                 nes_oe_cpu;
  logic                 nes_oe_ppu;

  logic [SD_ADDR_W-1:0] sd_addr;
  logic                 sd_we;
  logic [7:0]           sd_din;
  logic                 sd_oe_a;
  logic                 sd_oe_b;

  modport master (
    input  nes_addr, nes_we, nes_din,
    input  nes_oe_cpu, nes_oe_ppu,
    output sd_addr, sd_we, sd_din,
    output sd_oe_a, sd_oe_b
  );

  modport slave (
    output nes_addr, nes_we, nes_din,
    output nes_oe_cpu, nes_oe_ppu,
    input  sd_addr, sd_we, sd_din,
    input  sd_oe_a, sd_oe_b
  );

endinterface

// File: rtl/nes_arb_fifo.sv
// nes_arb_fifo: synchronous loader write FIFO, DEPTH a power of two.
// Ports: clk, reset_n (sync, low), push/din, pop/dout (head), full, empty, count.
module nes_arb_fifo
  import nes_mem_pkg::*;
#(
  parameter type T     = ld_entry_t,
  parameter int  DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  T mem [DEPTH];

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  // A pop frees the slot in the same cycle, so a full FIFO still
  // accepts a simultaneous push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, do_push}
                     - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  assign dout  = mem[rp];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/nes_mem_arbiter.sv
// nes_mem_arbiter: shares the SDRAM port between ROM loader and NES bus,
// and generates the 4-phase nes_ce / sd_clkref.
// Ports: clk, reset_n (sync, low), downloading, ld_wr/ld_addr/ld_data,
//   bus (master: nes_* in, sd_* out), nes_ce, sd_clkref, nes_hold, ld_overflow.
// Option: ARB_PERF_EN adds perf_ld_writes and perf_max_fill.
module nes_mem_arbiter
  import nes_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int SD_ADDR_W  = SD_ADDR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        downloading,
  input  logic                        ld_wr,
  input  logic [ADDR_W-1:0]           ld_addr,
  input  logic [7:0]                  ld_data,
  nes_mem_arbiter_if.master           bus,
  output logic                        nes_ce,
  output logic                        sd_clkref,
  output logic                        nes_hold,
  output logic                        ld_overflow
`ifdef ARB_PERF_EN
  ,
  output logic [23:0]                 perf_ld_writes,
  output logic [$clog2(FIFO_DEPTH):0] perf_max_fill
`endif
);

  logic [1:0]  phase;
  logic        ph_ce;
  arb_state_e  state;
  arb_state_e  state_nx;

  ld_entry_t   f_din;
  ld_entry_t   f_dout;
  logic        f_full;
  logic        f_empty;
  logic        f_pop;
  logic [$clog2(FIFO_DEPTH):0] f_cnt;

  logic        wr_act;
  ld_entry_t   wr_ent;

  assign ph_ce     = (phase == PH_CE);
  assign nes_ce    = ph_ce;
  assign sd_clkref = phase[1];
  assign nes_hold  = (state != ARB_NES);

  assign f_din = '{addr: ld_addr, data: ld_data};
  assign f_pop = ph_ce && (state != ARB_NES) && !f_empty;

  nes_arb_fifo #(
    .T     (ld_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (ld_wr),
    .din     (f_din),
    .pop     (f_pop),
    .dout    (f_dout),
    .full    (f_full),
    .empty   (f_empty),
    .count   (f_cnt)
  );

  // Leaving LOAD/DRAIN only when nothing is left to pop means the last
  // popped write has already had its full 4-clk window.
  always_comb begin
    state_nx = state;
    if (ph_ce) begin
      unique case (state)
        ARB_NES:   if (downloading) state_nx = ARB_LOAD;
        ARB_LOAD:  if (!downloading)
                     state_nx = f_empty ? ARB_NES : ARB_DRAIN;
        ARB_DRAIN: if (f_empty) state_nx = ARB_NES;
        default:   state_nx = ARB_NES;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase <= '0;
      state <= ARB_NES;
    end else begin
      phase <= phase + 2'd1;
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_act      <= 1'b0;
      wr_ent      <= '0;
      ld_overflow <= 1'b0;
    end else begin
      if (ph_ce && state != ARB_NES) begin
        wr_act <= !f_empty;
        if (!f_empty) wr_ent <= f_dout;
      end
      if (ld_wr && f_full && !f_pop) ld_overflow <= 1'b1;
    end
  end

  // Registered mux: follows state/slot one clk after they change.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.sd_addr <= '0;
      bus.sd_we   <= 1'b0;
      bus.sd_din  <= '0;
      bus.sd_oe_a <= 1'b0;
      bus.sd_oe_b <= 1'b0;
    end else if (state == ARB_NES) begin
      bus.sd_addr <= SD_ADDR_W'(bus.nes_addr);
      bus.sd_we   <= bus.nes_we;
      bus.sd_din  <= bus.nes_din;
      bus.sd_oe_a <= bus.nes_oe_cpu;
      bus.sd_oe_b <= bus.nes_oe_ppu;
    end else begin
      bus.sd_addr <= SD_ADDR_W'(wr_ent.addr);
      bus.sd_we   <= wr_act;
      bus.sd_din  <= wr_ent.data;
      bus.sd_oe_a <= 1'b0;
      bus.sd_oe_b <= 1'b0;
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      perf_ld_writes <= '0;
      perf_max_fill  <= '0;
    end else begin
      if (f_pop && perf_ld_writes != '1)
        perf_ld_writes <= perf_ld_writes + 24'd1;
      if (f_cnt > perf_max_fill)
        perf_max_fill <= f_cnt;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^f_cnt;
`endif

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// tb_nes_mem_arbiter: directed self-checking bench for nes_mem_arbiter.
// Write windows on sd_we are captured by a negedge monitor.
module tb_nes_mem_arbiter;
  import nes_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        downloading = 1'b0;
  logic        ld_wr = 1'b0;
  logic [21:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        nes_ce, sd_clkref, nes_hold, ld_overflow;
`ifdef ARB_PERF_EN
  logic [23:0] perf_ld_writes;
  logic [2:0]  perf_max_fill;
`endif

  nes_mem_arbiter_if bus ();

  nes_mem_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .downloading (downloading),
    .ld_wr       (ld_wr),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .bus         (bus),
    .nes_ce      (nes_ce),
    .sd_clkref   (sd_clkref),
    .nes_hold    (nes_hold),
    .ld_overflow (ld_overflow)
`ifdef ARB_PERF_EN
    ,
    .perf_ld_writes (perf_ld_writes),
    .perf_max_fill  (perf_max_fill)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ph = 0;

  logic [24:0] w_addr [$];
  logic [7:0]  w_data [$];
  int          w_len  [$];
  logic        p_we = 1'b0;
  logic [24:0] p_addr = '0;
  logic [7:0]  p_din = '0;

  always @(negedge clk) begin
    if (bus.sd_we === 1'b1) begin
      if (!p_we || bus.sd_addr != p_addr || bus.sd_din != p_din) begin
        w_addr.push_back(bus.sd_addr);
        w_data.push_back(bus.sd_din);
        w_len.push_back(1);
      end else begin
        int k;
        k = w_len.size() - 1;
        w_len[k] = w_len[k] + 1;
      end
    end
    p_we   = (bus.sd_we === 1'b1);
    p_addr = bus.sd_addr;
    p_din  = bus.sd_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      ph = reset_n ? (ph + 1) % 4 : 0;
      #1;
    end
  endtask

  task automatic tick_ld(input int n);
    repeat (n) begin
      tick();
      chk("ld_oe_a", 32'(bus.sd_oe_a), 0);
      chk("ld_oe_b", 32'(bus.sd_oe_b), 0);
      chk("ld_hold", 32'(nes_hold), 1);
    end
  endtask

  task automatic wait_ph(input int p);
    for (int i = 0; i < 4 && ph != p; i++) tick();
  endtask

  task automatic chk_win(input string tag, input int idx,
                         input logic [24:0] a, input logic [7:0] d);
    chk({tag, "_addr"}, 32'(w_addr[idx]), 32'(a));
    chk({tag, "_data"}, 32'(w_data[idx]), 32'(d));
    chk({tag, "_len"},  32'(w_len[idx]), 4);
  endtask

  initial begin
    logic [7:0]  exp_ce;
    logic [7:0]  exp_ref;
    logic [21:0] a3 [3];
    logic [7:0]  d3 [3];
    int base;

    bus.nes_addr   = '0;
    bus.nes_we     = 1'b0;
    bus.nes_din    = '0;
    bus.nes_oe_cpu = 1'b0;
    bus.nes_oe_ppu = 1'b0;

    // 1: reset, then free-running phase
    tick(2);
    chk("rst_ce",   32'(nes_ce), 0);
    chk("rst_ref",  32'(sd_clkref), 0);
    chk("rst_hold", 32'(nes_hold), 0);
    chk("rst_ovf",  32'(ld_overflow), 0);
    chk("rst_we",   32'(bus.sd_we), 0);
    chk("rst_addr", 32'(bus.sd_addr), 0);
    reset_n = 1'b1;
    exp_ce  = 8'b1000_1000;
    exp_ref = 8'b1100_1100;
    for (int k = 0; k < 8; k++) begin
      chk("ph_ce",   32'(nes_ce), 32'(exp_ce[k]));
      chk("ph_ref",  32'(sd_clkref), 32'(exp_ref[k]));
      chk("ph_hold", 32'(nes_hold), 0);
      tick();
    end

    // 2: NES pass-through, one clk latency
    bus.nes_addr   = 22'h1234;
    bus.nes_oe_cpu = 1'b1;
    chk("nes_lat", 32'(bus.sd_oe_a), 0);
    tick();
    chk("nes_addr", 32'(bus.sd_addr), 32'h0001234);
    chk("nes_oe_a", 32'(bus.sd_oe_a), 1);
    chk("nes_oe_b", 32'(bus.sd_oe_b), 0);
    chk("nes_we0",  32'(bus.sd_we), 0);
    bus.nes_addr   = 22'h3FFFFF;
    bus.nes_oe_cpu = 1'b0;
    bus.nes_oe_ppu = 1'b1;
    bus.nes_we     = 1'b1;
    bus.nes_din    = 8'h5A;
    tick();
    chk("nes_addr_max", 32'(bus.sd_addr), 32'h03FFFFF);
    chk("nes_oe_b1",    32'(bus.sd_oe_b), 1);
    chk("nes_oe_a0",    32'(bus.sd_oe_a), 0);
    chk("nes_we1",      32'(bus.sd_we), 1);
    chk("nes_din",      32'(bus.sd_din), 32'h5A);
    bus.nes_we     = 1'b0;
    bus.nes_oe_ppu = 1'b0;
    tick(2);
    chk("nes_idle_we", 32'(bus.sd_we), 0);

    // 3: three spaced loader writes, NES requests ignored
    base = w_addr.size();
    downloading = 1'b1;
    wait_ph(3);
    chk("pre_load_hold", 32'(nes_hold), 0);
    tick();
    chk("load_hold", 32'(nes_hold), 1);
    tick();
    bus.nes_oe_cpu = 1'b1;
    bus.nes_oe_ppu = 1'b1;
    bus.nes_we     = 1'b1;
    bus.nes_addr   = 22'h155555;
    a3[0] = 22'h000000; d3[0] = 8'hAA;
    a3[1] = 22'h000001; d3[1] = 8'hBB;
    a3[2] = 22'h200000; d3[2] = 8'hCC;
    for (int i = 0; i < 3; i++) begin
      ld_wr = 1'b1; ld_addr = a3[i]; ld_data = d3[i];
      tick_ld(1);
      ld_wr = 1'b0;
      tick_ld(7);
    end
    tick_ld(8);
    chk("t3_count", 32'(w_addr.size() - base), 3);
    for (int i = 0; i < 3; i++)
      chk_win("t3_w", base + i, 25'(a3[i]), d3[i]);

    // 4: burst of 6, FIFO holds 4, one pop lands mid-burst
    chk("t4_ovf0", 32'(ld_overflow), 0);
    wait_ph(0);
    base = w_addr.size();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) chk("t4_ovf_full", 32'(ld_overflow), 0);
      ld_wr = 1'b1;
      ld_addr = 22'h000100 + 22'(i);
      ld_data = 8'h10 + 8'(i);
      tick();
    end
    ld_wr = 1'b0;
    chk("t4_ovf1", 32'(ld_overflow), 1);
    tick_ld(28);
    chk("t4_count", 32'(w_addr.size() - base), 5);
    for (int i = 0; i < 5; i++)
      chk_win("t4_w", base + i, 25'h100 + 25'(i), 8'h10 + 8'(i));

    // 5: download ends with 2 queued -> DRAIN -> NES
    bus.nes_oe_cpu = 1'b0;
    bus.nes_oe_ppu = 1'b0;
    bus.nes_we     = 1'b0;
    wait_ph(0);
    base = w_addr.size();
    ld_wr = 1'b1; ld_addr = 22'h2ABCDE; ld_data = 8'h77;
    tick();
    ld_addr = 22'h000010; ld_data = 8'h88;
    tick();
    ld_wr = 1'b0;
    downloading = 1'b0;
    tick();
    chk("t5_hold_a", 32'(nes_hold), 1);
    tick();
    chk("t5_hold_b", 32'(nes_hold), 1);
    tick(4);
    chk("t5_hold_c", 32'(nes_hold), 1);
    tick(3);
    chk("t5_hold_d", 32'(nes_hold), 1);
    tick();
    chk("t5_hold_fall", 32'(nes_hold), 0);
    tick();
    chk("t5_we_off", 32'(bus.sd_we), 0);
    chk("t5_count", 32'(w_addr.size() - base), 2);
    chk_win("t5_w0", base,     25'h2ABCDE, 8'h77);
    chk_win("t5_w1", base + 1, 25'h000010, 8'h88);

    // 6: reset mid-LOAD with 3 queued
    downloading = 1'b1;
    wait_ph(3);
    tick();
    base = w_addr.size();
    for (int i = 0; i < 3; i++) begin
      ld_wr = 1'b1;
      ld_addr = 22'h000300 + 22'(i);
      ld_data = 8'hE0 + 8'(i);
      tick();
    end
    ld_wr = 1'b0;
    reset_n = 1'b0;
    tick();
    chk("t6_we",   32'(bus.sd_we), 0);
    chk("t6_addr", 32'(bus.sd_addr), 0);
    chk("t6_din",  32'(bus.sd_din), 0);
    chk("t6_oe",   32'({bus.sd_oe_a, bus.sd_oe_b}), 0);
    chk("t6_hold", 32'(nes_hold), 0);
    chk("t6_ce",   32'(nes_ce), 0);
    chk("t6_ref",  32'(sd_clkref), 0);
    chk("t6_ovf",  32'(ld_overflow), 0);
    reset_n = 1'b1;
    tick(16);
    chk("t6_relo_hold", 32'(nes_hold), 1);
    chk("t6_no_writes", 32'(w_addr.size() - base), 0);
    downloading = 1'b0;
    tick(8);
    chk("t6_end_hold", 32'(nes_hold), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
